// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART data/FIFO sizing constants
//
// Purpose: default widths shared by the UART receiver, transmitter and the
//          receive FIFO (data byte width and FIFO address width).
// Contents:
//   UART_DATA_W       width of one UART byte/word
//   UART_FIFO_ADDR_W  log2 of the receive FIFO depth
// Optional feature macro used by importers: UART_FIFO_OVF_EN
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_FIFO_ADDR_W = 4;

endpackage

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, count and flag control for the UART receive FIFO
//
// Purpose: qualifies push/pop strobes, keeps the write/read pointers and the
//          entry count, and derives empty/full. With UART_FIFO_OVF_EN defined
//          it also holds the sticky overflow flag.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   wr, rd           raw push / pop strobes
//   ovf_clr          clears overflow (UART_FIFO_OVF_EN only)
//   overflow         sticky dropped-push flag (UART_FIFO_OVF_EN only)
//   w_en             qualified push: write mem[w_addr] this edge
//   w_addr, r_addr   storage write / read pointers
//   empty, full      count == 0 / count == 2**ADDR_W
//   count            stored entries, 0..2**ADDR_W
module fifo_ctrl
  import uart_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic              rd,
`ifdef UART_FIFO_OVF_EN
  input  logic              ovf_clr,
  output logic              overflow,
`endif
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   cnt;
  logic              push;
  logic              pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH);

  // A push into a full FIFO is accepted only when the head leaves on the
  // same edge; a pop from an empty FIFO is always ignored, so wr&&rd while
  // empty degenerates to a plain push (no bypass).
  assign push = wr && (!full || rd);
  assign pop  = rd && !empty;

  assign w_en   = push;
  assign w_addr = w_ptr;
  assign r_addr = r_ptr;
  assign count  = cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
    end else begin
      if (push) w_ptr <= w_ptr + 1'b1;
      if (pop)  r_ptr <= r_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

`ifdef UART_FIFO_OVF_EN
  // Set has priority over clear so a drop coinciding with ovf_clr is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr && full && !rd) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive byte FIFO behind the UART receiver
//
// Purpose: buffers bytes from the UART receiver (rx_done_tick/dout) until the
//          host pops them; the head byte is always visible on r_data while
//          not empty. Optional macro UART_FIFO_OVF_EN adds a sticky overflow
//          flag with its clear input.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   wr, w_data     push strobe and byte
//   rd             pop strobe, removes current head
//   r_data         head byte, valid only when empty == 0
//   empty, full    FIFO status flags
//   count          stored entries, 0..2**ADDR_W
//   overflow       sticky dropped-push flag (UART_FIFO_OVF_EN only)
//   ovf_clr        clears overflow (UART_FIFO_OVF_EN only)
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
`ifdef UART_FIFO_OVF_EN
  ,
  output logic              overflow,
  input  logic              ovf_clr
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;

  fifo_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (wr),
    .rd       (rd),
`ifdef UART_FIFO_OVF_EN
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
`endif
    .w_en     (w_en),
    .w_addr   (w_addr),
    .r_addr   (r_addr),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

  // Storage is intentionally not reset; empty qualifies r_data.
  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  // Combinational read gives show-ahead behaviour.
  assign r_data = mem[r_addr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking directed bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset_n;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
`ifdef UART_FIFO_OVF_EN
  logic       overflow;
  logic       ovf_clr;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q [$];

  uart_rx_fifo dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (wr),
    .w_data   (w_data),
    .rd       (rd),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count)
`ifdef UART_FIFO_OVF_EN
    ,
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one clock of strobes, then sample 1 time unit after the edge.
  task automatic op(input logic w, input logic r, input logic [7:0] d);
    wr     = w;
    rd     = r;
    w_data = d;
    @(posedge clk);
    #1;
    wr     = 1'b0;
    rd     = 1'b0;
    w_data = 8'h00;
  endtask

  initial begin
    logic [7:0] exp_b;
    wr      = 1'b0;
    rd      = 1'b0;
    w_data  = 8'h00;
    reset_n = 1'b0;
`ifdef UART_FIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1. reset values
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_count", 32'(count), 32'd0);
`ifdef UART_FIFO_OVF_EN
    check("rst_ovf", 32'(overflow), 32'd0);
`endif

    // pop while empty is ignored
    op(1'b0, 1'b1, 8'h00);
    check("rd_empty_count", 32'(count), 32'd0);
    check("rd_empty_empty", 32'(empty), 32'd1);

    // 2. basic push/pop
    op(1'b1, 1'b0, 8'hA5);
    check("push1_empty", 32'(empty),  32'd0);
    check("push1_head",  32'(r_data), 32'hA5);
    op(1'b1, 1'b0, 8'h3C);
    check("push2_count", 32'(count),  32'd2);
    check("push2_head",  32'(r_data), 32'hA5);
    op(1'b0, 1'b1, 8'h00);
    check("pop1_head",  32'(r_data), 32'h3C);
    check("pop1_count", 32'(count),  32'd1);
    op(1'b0, 1'b1, 8'h00);
    check("pop2_empty", 32'(empty), 32'd1);
    check("pop2_count", 32'(count), 32'd0);

    // 3. fill, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 1'b0, 8'(i));
      if (i == 14) check("fill15_full", 32'(full), 32'd0);
    end
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd16);
    op(1'b1, 1'b0, 8'hFF);
    check("drop_count", 32'(count),  32'd16);
    check("drop_head",  32'(r_data), 32'h00);
`ifdef UART_FIFO_OVF_EN
    check("drop_ovf", 32'(overflow), 32'd1);
    // set and clear together: set wins
    ovf_clr = 1'b1;
    op(1'b1, 1'b0, 8'hFE);
    check("ovf_set_vs_clr", 32'(overflow), 32'd1);
    op(1'b0, 1'b0, 8'h00);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 32'(r_data), 32'(i));
      op(1'b0, 1'b1, 8'h00);
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_full",  32'(full),  32'd0);

    // 4. simultaneous push/pop while full
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(8'h10 + i));
    op(1'b1, 1'b1, 8'h55);
    check("fullrw_full",  32'(full),   32'd1);
    check("fullrw_count", 32'(count),  32'd16);
    check("fullrw_head",  32'(r_data), 32'h11);
`ifdef UART_FIFO_OVF_EN
    check("fullrw_ovf", 32'(overflow), 32'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      exp_b = (i == 15) ? 8'h55 : 8'(8'h11 + i);
      check("fullrw_drain", 32'(r_data), 32'(exp_b));
      op(1'b0, 1'b1, 8'h00);
    end
    check("fullrw_empty", 32'(empty), 32'd1);

    // 5. simultaneous push/pop while empty: push only
    op(1'b1, 1'b1, 8'h77);
    check("emptyrw_empty", 32'(empty),  32'd0);
    check("emptyrw_count", 32'(count),  32'd1);
    check("emptyrw_head",  32'(r_data), 32'h77);
    // partially filled: both occur, count unchanged
    op(1'b1, 1'b1, 8'h78);
    check("partrw_count", 32'(count),  32'd1);
    check("partrw_head",  32'(r_data), 32'h78);
    op(1'b0, 1'b1, 8'h00);
    check("partrw_empty", 32'(empty), 32'd1);

    // 6. 40 cycles across pointer wrap, ending at count=5, then async reset
    model_q.delete();
    for (int i = 0; i < 40; i++) begin
      logic r;
      r = (i >= 5);
      if (r && model_q.size() != 0) void'(model_q.pop_front());
      model_q.push_back(8'(8'h80 + i));
      op(1'b1, r, 8'(8'h80 + i));
      check("wrap_count", 32'(count),  32'(model_q.size()));
      check("wrap_head",  32'(r_data), 32'(model_q[0]));
    end
    check("wrap_final_count", 32'(count), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full",  32'(full),  32'd0);
    check("arst_count", 32'(count), 32'd0);
    wr = 1'b1;
    w_data = 8'hEE;
    @(posedge clk);
    #1;
    wr = 1'b0;
    check("arst_push_lost", 32'(count), 32'd0);
    reset_n = 1'b1;
    op(1'b0, 1'b0, 8'h00);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
